deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Receive-side partner of the link serializer: collects sixteen 4-bit phits from the serial link and reassembles one 64-bit flit, tagged with its VC.
- Sits between the serial link and the router input port.
- Holds completed flits in a small output FIFO with valid/ready handshake toward the router.
- The link has no backpressure, so a full FIFO causes a counted drop.

Parameters:
- FLIT_W, 64, flit width in bits.
- PHIT_W, 4, serial phit width; FLIT_W/PHIT_W (16) phits per flit.
- FIFO_DEPTH, 2, completed-flit FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- data_in  in  PHIT_W  serial phit from link.
- valid_in  in  1  phit valid.
- vc_in  in  2  VC tag accompanying each phit.
- data_out  out  FLIT_W  reassembled flit (FIFO head).
- valid_out  out  1  FIFO non-empty.
- vc_out  out  2  VC of head flit.
- ready_in  in  1  router accepts head flit when valid_out && ready_in.
- vc_error  out  1  one-cycle pulse: VC changed mid-flit, partial flit discarded.
- overflow  out  1  one-cycle pulse: completed flit dropped, FIFO full.

Behaviour:
- Reset (rst=0, async): all outputs 0; phit count 0; assembly buffer 0; FIFO empty; state IDLE.
- Ordering: first phit of a flit goes to bits [3:0]; phit k goes to [4k+3:4k], little-endian (matches serializer).
- States: IDLE, ASSEMBLE.
  - IDLE + valid_in: store phit 0, latch vc_in, count=1, go ASSEMBLE.
  - ASSEMBLE + valid_in with vc_in == latched VC: store phit at count, count+1.
  - ASSEMBLE + !valid_in: hold count and buffer; gaps of any length are legal.
  - ASSEMBLE + valid_in with vc_in != latched VC: discard partial flit; pulse vc_error next cycle; treat this phit as phit 0 of a new flit (count=1, latch new VC); stay ASSEMBLE.
  - Phit at count==15 accepted: form the flit from the 15 stored phits plus the current phit; push to FIFO; count=0; go IDLE.
- Latency: 16th phit sampled at edge N; valid_out=1 with the flit on data_out after edge N if the FIFO was empty (one-cycle push-to-visible). Back-to-back flits need no idle cycle between them.
- FIFO: registered head, so data_out/vc_out stay stable while valid_out && !ready_in.
  - Pop on valid_out && ready_in.
  - Push and pop in the same cycle are both allowed, including when full: the push succeeds and occupancy is unchanged.
  - Push when full and no pop: flit dropped, FIFO unchanged, overflow pulses for one cycle after the edge.
- ready_in is ignored while the FIFO is empty.
- vc_error and overflow are registered single-cycle pulses and may assert in the same cycle.
- Reset asserted mid-flit or with the FIFO non-empty: everything is cleared immediately and asynchronously; no partial or queued flit survives.

Decomposition:
- Shared package constants: FLIT_W, PHIT_W, PHITS_PER_FLIT (=FLIT_W/PHIT_W), VC_W=2; typedef flit_t {vc, data}.
- Sub-module: flit_fifo (parameterised synchronous FIFO with count, full, empty, simultaneous push/pop). Reused later by router input buffers.

Test Plan:
- Single flit: drive 16 consecutive phits of 64'hFEDC_BA98_7654_3210 (phit0=4'h0, ...), vc_in=2, ready_in=1 -> after the 16th phit's edge: valid_out=1 for one cycle, data_out=64'hFEDC_BA98_7654_3210, vc_out=2; no pulses.
- Gaps: same flit with valid_in low for 3 cycles after phits 4 and 11 -> identical flit, valid_out rises one cycle after the last phit.
- VC switch: 5 phits on vc 1, then 16 phits of 64'h1111_2222_3333_4444 on vc 3 -> vc_error pulses once; only one flit is output: 64'h1111_2222_3333_4444 on vc 3.
- Backpressure/overflow: ready_in=0, send 3 back-to-back flits A, B, C -> A and B queued; overflow pulses once after C's 16th phit; data_out holds A. Raise ready_in -> A then B delivered, valid_out falls.
- Full with simultaneous pop: FIFO full; ready_in=1 in the same cycle a third flit completes -> no overflow; output order A, B, C.
- Reset mid-flit: assert rst=0 after 7 phits, release, send a fresh flit -> all outputs 0 during reset; no spurious flit; fresh flit is correct.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared constants, types and helpers for the link deserializer and its FIFO.
package deserializer_pkg;

   localparam int FLIT_W             = 64;
   localparam int PHIT_W             = 4;
   localparam int PHITS_PER_FLIT     = FLIT_W / PHIT_W;
   localparam int VC_W               = 2;
   localparam int CNT_W              = $clog2(PHITS_PER_FLIT);
   localparam int DEFAULT_FIFO_DEPTH = 2;

   // Assembly state: waiting for a first phit, or part-way through a flit.
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_ASSEMBLE = 1'b1
   } asm_state_t;

   // A completed flit as queued toward the router.
   typedef struct packed {
      logic [VC_W-1:0]   vc;
      logic [FLIT_W-1:0] data;
   } flit_t;

   localparam int FLIT_T_W = $bits(flit_t);

   // Drop one phit into its little-endian slot of a flit-wide buffer.
   function automatic logic [FLIT_W-1:0] place_phit(
      input logic [FLIT_W-1:0] buf_in,
      input logic [PHIT_W-1:0] phit,
      input logic [CNT_W-1:0]  slot
   );
      logic [FLIT_W-1:0] result;
      result = buf_in;
      result[slot*PHIT_W +: PHIT_W] = phit;
      return result;
   endfunction

endpackage

// File: rtl/deserializer_if.sv
// Link-side and router-side signals of the deserializer, bundled as one interface.
interface deserializer_if;
   import deserializer_pkg::*;

   // serial link side
   logic [PHIT_W-1:0] data_in;
   logic              valid_in;
   logic [VC_W-1:0]   vc_in;

   // router side
   logic [FLIT_W-1:0] data_out;
   logic              valid_out;
   logic [VC_W-1:0]   vc_out;
   logic              ready_in;

   // status pulses
   logic              vc_error;
   logic              overflow;

   // Driven by the link/router environment.
   modport master (
      output data_in, valid_in, vc_in, ready_in,
      input  data_out, valid_out, vc_out, vc_error, overflow
   );

   // Driven by the deserializer.
   modport slave (
      input  data_in, valid_in, vc_in, ready_in,
      output data_out, valid_out, vc_out, vc_error, overflow
   );

endinterface

// File: rtl/deserializer_flit_fifo.sv
// Small synchronous shift FIFO. Entry 0 is always the head, so the head output
// comes straight from a register and cannot change while it is not popped.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module flit_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem      [DEPTH];
   logic [WIDTH-1:0] mem_next [DEPTH];
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [CW-1:0]    wr_slot;
   logic             do_pop;
   logic             do_push;

   assign empty     = (count == CW'(0));
   assign full      = (count == CW'(DEPTH));
   assign head_data = mem[0];

   // Resolve which operations take effect and build the next contents.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);

      if (do_pop) begin
         wr_slot = count - CW'(1);
      end else begin
         wr_slot = count;
      end

      if (do_push && !do_pop) begin
         count_next = count + CW'(1);
      end else if (do_pop && !do_push) begin
         count_next = count - CW'(1);
      end else begin
         count_next = count;
      end

      for (int i = 0; i < DEPTH; i++) begin
         if (do_push && (wr_slot == CW'(i))) begin
            mem_next[i] = push_data;
         end else if (do_pop && (i < DEPTH - 1)) begin
            mem_next[i] = mem[(i + 1) % DEPTH];
         end else begin
            mem_next[i] = mem[i];
         end
      end
   end

   // Storage and occupancy registers; reset empties and zeroes every entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= {WIDTH{1'b0}};
         end
      end else begin
         count <= count_next;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= mem_next[i];
         end
      end
   end

endmodule

// File: rtl/deserializer.sv
// Link deserializer: gathers sixteen 4-bit phits into a 64-bit flit tagged with
// its VC and queues completed flits toward the router. The link cannot be
// stalled, so a flit that completes while the queue is full and not draining
// is dropped and reported on overflow. A VC change part-way through a flit
// abandons the partial flit and restarts assembly with the new phit.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           rst,
   deserializer_if.slave  link
);

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PHITS_PER_FLIT - 1);

   asm_state_t        state;
   logic [CNT_W-1:0]  phit_cnt;
   logic [FLIT_W-1:0] asm_buf;
   logic [VC_W-1:0]   cur_vc;
   logic              err_pulse;
   logic              ovf_pulse;

   logic              same_vc;
   logic              flit_done;
   flit_t             push_flit;
   flit_t             head_flit;
   logic [FLIT_T_W-1:0] head_bits;
   logic              fifo_full;
   logic              fifo_empty;

   // Detect the phit that completes a flit and form that flit on the fly,
   // so it reaches the FIFO on the same edge the last phit is sampled.
   always_comb begin
      same_vc        = (link.vc_in == cur_vc);
      push_flit.vc   = cur_vc;
      push_flit.data = place_phit(asm_buf, link.data_in, LAST_SLOT);
      if ((state == ST_ASSEMBLE) && link.valid_in && same_vc && (phit_cnt == LAST_SLOT)) begin
         flit_done = 1'b1;
      end else begin
         flit_done = 1'b0;
      end
   end

   // Assembly state machine plus the registered error/overflow pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         phit_cnt  <= {CNT_W{1'b0}};
         asm_buf   <= {FLIT_W{1'b0}};
         cur_vc    <= {VC_W{1'b0}};
         err_pulse <= 1'b0;
         ovf_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         // full with no pop in the same cycle means the new flit has nowhere to go
         ovf_pulse <= flit_done && fifo_full && !link.ready_in;
         case (state)
            ST_IDLE: begin
               if (link.valid_in) begin
                  asm_buf  <= place_phit({FLIT_W{1'b0}}, link.data_in, {CNT_W{1'b0}});
                  cur_vc   <= link.vc_in;
                  phit_cnt <= CNT_W'(1);
                  state    <= ST_ASSEMBLE;
               end else begin
                  state    <= ST_IDLE;
               end
            end
            ST_ASSEMBLE: begin
               if (link.valid_in && !same_vc) begin
                  // abandon the partial flit; this phit starts a new one
                  err_pulse <= 1'b1;
                  asm_buf   <= place_phit({FLIT_W{1'b0}}, link.data_in, {CNT_W{1'b0}});
                  cur_vc    <= link.vc_in;
                  phit_cnt  <= CNT_W'(1);
                  state     <= ST_ASSEMBLE;
               end else if (link.valid_in && (phit_cnt == LAST_SLOT)) begin
                  phit_cnt  <= {CNT_W{1'b0}};
                  state     <= ST_IDLE;
               end else if (link.valid_in) begin
                  asm_buf   <= place_phit(asm_buf, link.data_in, phit_cnt);
                  phit_cnt  <= phit_cnt + CNT_W'(1);
                  state     <= ST_ASSEMBLE;
               end else begin
                  // gap on the link: hold everything
                  state     <= ST_ASSEMBLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               phit_cnt <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   flit_fifo #(
      .WIDTH (FLIT_T_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (flit_done),
      .push_data (push_flit),
      .pop       (link.ready_in),
      .head_data (head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_flit      = flit_t'(head_bits);
   assign link.data_out  = head_flit.data;
   assign link.vc_out    = head_flit.vc;
   assign link.valid_out = !fifo_empty;
   assign link.vc_error  = err_pulse;
   assign link.overflow  = ovf_pulse;

endmodule

// File: tb/tb_deserializer.sv
// Bench for the deserializer: directed scenarios plus randomized traffic, checked
// against a phit-list / occupancy reference model through an expected-flit queue.
module tb_deserializer;
   import deserializer_pkg::*;

   logic clk = 1'b0;
   logic rst;

   deserializer_if dif();

   deserializer #(.FIFO_DEPTH(DEFAULT_FIFO_DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (dif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int n_delivered = 0;
   int n_vcerr_seen = 0;
   int n_ovf_seen = 0;

   // reference model state
   flit_t             exp_q[$];
   logic [PHIT_W-1:0] m_phits[$];
   logic [VC_W-1:0]   m_vc = 2'd0;
   int                m_occ = 0;
   flit_t             m_flit;
   logic              exp_vcerr = 1'b0;
   logic              exp_ovf = 1'b0;

   bit   rand_ready = 1'b0;
   logic rdy_val = 1'b1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference model: phits are collected in a list per VC run; a full list
   // becomes a flit that either enters the modelled queue or is dropped.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         m_phits.delete();
         m_vc = 2'd0;
         m_occ = 0;
         exp_vcerr = 1'b0;
         exp_ovf = 1'b0;
      end else begin
         exp_vcerr = 1'b0;
         exp_ovf = 1'b0;
         if (dif.ready_in && m_occ > 0) m_occ--;
         if (dif.valid_in) begin
            if (m_phits.size() > 0 && dif.vc_in != m_vc) begin
               exp_vcerr = 1'b1;
               m_phits.delete();
            end
            if (m_phits.size() == 0) m_vc = dif.vc_in;
            m_phits.push_back(dif.data_in);
            if (m_phits.size() == PHITS_PER_FLIT) begin
               m_flit.vc = m_vc;
               m_flit.data = 64'd0;
               for (int k = 0; k < PHITS_PER_FLIT; k++)
                  m_flit.data = m_flit.data | (64'(m_phits[k]) << (PHIT_W * k));
               if (m_occ < DEFAULT_FIFO_DEPTH) begin
                  m_occ++;
                  exp_q.push_back(m_flit);
               end else begin
                  exp_ovf = 1'b1;
               end
               m_phits.delete();
            end
         end
      end
   end

   // Per-cycle checks of valid_out and the status pulses.
   always @(negedge clk) begin
      #1;
      if (!rst) begin
         chk("rst_valid_out", 64'(dif.valid_out), 64'd0);
         chk("rst_data_out", dif.data_out, 64'd0);
         chk("rst_vc_out", 64'(dif.vc_out), 64'd0);
         chk("rst_vc_error", 64'(dif.vc_error), 64'd0);
         chk("rst_overflow", 64'(dif.overflow), 64'd0);
      end else begin
         chk("valid_out", 64'(dif.valid_out), 64'(m_occ > 0));
         chk("vc_error", 64'(dif.vc_error), 64'(exp_vcerr));
         chk("overflow", 64'(dif.overflow), 64'(exp_ovf));
         if (dif.vc_error) n_vcerr_seen++;
         if (dif.overflow) n_ovf_seen++;
      end
   end

   // Monitor: whenever a flit is presented, compare it with the queue head and
   // retire the entry when the router takes it.
   always @(negedge clk) begin
      #2;
      if (rst && dif.valid_out) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_flit: got data %h vc %0d expected no flit", dif.data_out, dif.vc_out);
         end else begin
            chk("head_data", dif.data_out, exp_q[0].data);
            chk("head_vc", 64'(dif.vc_out), 64'(exp_q[0].vc));
            if (dif.ready_in) begin
               void'(exp_q.pop_front());
               n_delivered++;
            end
         end
      end
   end

   task automatic step(input logic v, input logic [PHIT_W-1:0] d, input logic [VC_W-1:0] vc);
      @(negedge clk);
      dif.valid_in = v;
      dif.data_in  = d;
      dif.vc_in    = vc;
      dif.ready_in = rand_ready ? 1'($urandom_range(0, 1)) : rdy_val;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
   endtask

   task automatic send_flit(input logic [63:0] f, input logic [VC_W-1:0] vc,
                            input int gap_a, input int gap_b, input int gap_len);
      logic [63:0] t;
      t = f;
      for (int k = 0; k < PHITS_PER_FLIT; k++) begin
         step(1'b1, t[PHIT_W*k +: PHIT_W], vc);
         if (k == gap_a || k == gap_b) gap(gap_len);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] fa, fb, fc, t;
      logic [1:0]  rvc;
      fa = 64'hA5A5_0F0F_1234_5678;
      fb = 64'h0BAD_CAFE_DEAD_BEEF;
      fc = 64'h7777_8888_9999_AAAA;
      dif.valid_in = 1'b0;
      dif.data_in  = 4'h0;
      dif.vc_in    = 2'd0;
      dif.ready_in = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // single flit
      rdy_val = 1'b1;
      send_flit(64'hFEDC_BA98_7654_3210, 2'd2, -1, -1, 0);
      gap(3);
      chk("t1_delivered", 64'(n_delivered), 64'd1);

      // gaps inside the flit
      send_flit(64'hFEDC_BA98_7654_3210, 2'd2, 4, 11, 3);
      gap(3);
      chk("t2_delivered", 64'(n_delivered), 64'd2);

      // VC switch mid-flit
      for (int k = 0; k < 5; k++) step(1'b1, 4'(k + 5), 2'd1);
      send_flit(64'h1111_2222_3333_4444, 2'd3, -1, -1, 0);
      gap(3);
      chk("t3_delivered", 64'(n_delivered), 64'd3);
      chk("t3_vc_error_pulses", 64'(n_vcerr_seen), 64'd1);

      // backpressure and overflow
      rdy_val = 1'b0;
      send_flit(fa, 2'd0, -1, -1, 0);
      send_flit(fb, 2'd1, -1, -1, 0);
      send_flit(fc, 2'd2, -1, -1, 0);
      gap(4);
      chk("t4_overflow_pulses", 64'(n_ovf_seen), 64'd1);
      chk("t4_head_holds_a", dif.data_out, fa);
      rdy_val = 1'b1;
      gap(4);
      chk("t4_delivered", 64'(n_delivered), 64'd5);

      // full FIFO with pop in the cycle the third flit completes
      rdy_val = 1'b0;
      send_flit(fa, 2'd0, -1, -1, 0);
      send_flit(fb, 2'd1, -1, -1, 0);
      t = fc;
      for (int k = 0; k < PHITS_PER_FLIT - 1; k++) step(1'b1, t[PHIT_W*k +: PHIT_W], 2'd2);
      rdy_val = 1'b1;
      step(1'b1, t[63:60], 2'd2);
      gap(4);
      chk("t5_no_overflow", 64'(n_ovf_seen), 64'd1);
      chk("t5_delivered", 64'(n_delivered), 64'd8);

      // reset with a queued flit and a partial flit in flight
      rdy_val = 1'b0;
      send_flit(fb, 2'd3, -1, -1, 0);
      t = fa;
      for (int k = 0; k < 7; k++) step(1'b1, t[PHIT_W*k +: PHIT_W], 2'd1);
      @(negedge clk);
      rst = 1'b0;
      dif.valid_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      rdy_val = 1'b1;
      gap(2);
      chk("t6_nothing_after_reset", 64'(dif.valid_out), 64'd0);
      send_flit(64'h0123_4567_89AB_CDEF, 2'd1, -1, -1, 0);
      gap(4);
      chk("t6_delivered", 64'(n_delivered), 64'd9);

      // randomized traffic with random gaps, VC switches and backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         rvc = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) begin
            int len;
            len = $urandom_range(1, 15);
            for (int k = 0; k < len; k++) step(1'b1, 4'($urandom_range(0, 15)), rvc);
            rvc = rvc ^ 2'($urandom_range(1, 3));
         end
         t = {$urandom, $urandom};
         send_flit(t, rvc, $urandom_range(0, 15), -1, $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 4));
      end
      rand_ready = 1'b0;
      rdy_val = 1'b1;
      gap(10);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("final_valid_out", 64'(dif.valid_out), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
